usb_auth_exchange_ctrl: RTL

//  Host-side sequencer for the Type-C authentication exchange. Debounces CC1/CC2 attach and

---
 rtl/usb_auth_exchange_ctrl_pkg.sv | 32 +++
 rtl/cc_attach_debounce.sv | 62 ++++++
 rtl/usb_auth_exchange_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/usb_auth_exchange_ctrl_pkg.sv
// Shared constants, state encoding and message helpers for the
// Type-C authentication exchange sequencer.
package usb_auth_exchange_ctrl_pkg;

    localparam int MSG_LEN         = 2080;
    localparam int PAYLOAD_LEN     = MSG_LEN - 32;
    localparam int HDR_VER_MSB     = MSG_LEN - 1;
    localparam int DEBOUNCE_CYCLES = 16;
    localparam int TIMEOUT_CYCLES  = 1000;

    localparam logic [7:0] PROTO_VER       = 8'h01;
    localparam logic [7:0] AUTH_TYPE_ERROR = 8'h7F;
    localparam logic [7:0] ERR_INVALID     = 8'h01;
    localparam logic [7:0] ERR_BUSY        = 8'h03;
    localparam logic [7:0] ERR_UNSPEC      = 8'h05;

    typedef enum logic [1:0] {
        S_DETACHED = 2'd0,
        S_IDLE     = 2'd1,
        S_FWD_WAIT = 2'd2,
        S_SEND     = 2'd3
    } auth_state_e;

    function automatic logic [MSG_LEN-1:0] error_msg(input logic [7:0] code);
        return {PROTO_VER, AUTH_TYPE_ERROR, code, 8'h00, {PAYLOAD_LEN{1'b0}}};
    endfunction

    function automatic logic ver_ok(input logic [MSG_LEN-1:0] m);
        return m[HDR_VER_MSB -: 8] == PROTO_VER;
    endfunction

endpackage

// File: rtl/cc_attach_debounce.sv
// Debounces the CC pair into attach/orientation; detach_evt marks the
// edge on which an established attach is being dropped.
module cc_attach_debounce
    import usb_auth_exchange_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic cc1,
    input  logic cc2,
    output logic attached,
    output logic orient,
    output logic detach_evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [1:0]       prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             att_q, att_d;
    logic             ori_q, ori_d;
    logic             match, stable, one_hot;

    // cnt holds the number of repeats after the first sample of a run,
    // so the DEBOUNCE_CYCLES-th identical sample sees cnt == CNT_THR
    always_comb begin
        match   = {cc1, cc2} == prev_q;
        one_hot = cc1 ^ cc2;
        stable  = match && (cnt_q >= CNT_THR);
        prev_d  = {cc1, cc2};
        cnt_d   = '0;
        if (match) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        att_d = att_q;
        ori_d = ori_q;
        if (stable) begin
            att_d = one_hot;
            ori_d = one_hot & cc2;
        end
        detach_evt = att_q && stable && !one_hot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            cnt_q  <= '0;
            att_q  <= 1'b0;
            ori_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            att_q  <= att_d;
            ori_q  <= ori_d;
        end
    end

    assign attached = att_q;
    assign orient   = ori_q;

endmodule

// File: rtl/usb_auth_exchange_ctrl.sv
// Host-side auth exchange sequencer: request capture, forward with
// timeout, response/error return and completed-exchange count.
module usb_auth_exchange_ctrl
    import usb_auth_exchange_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               cc1,
    input  logic               cc2,
    input  logic               req_valid,
    input  logic [MSG_LEN-1:0] req_msg,
    output logic               req_ready,
    output logic               fwd_valid,
    output logic [MSG_LEN-1:0] fwd_msg,
    input  logic               rsp_valid,
    input  logic [MSG_LEN-1:0] rsp_msg,
    output logic               resp_valid,
    output logic [MSG_LEN-1:0] resp_msg,
    input  logic               resp_ack,
    output logic               attached,
    output logic               orient,
    output logic [7:0]         exch_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    auth_state_e        state_q, state_d;
    logic [MSG_LEN-1:0] fwd_q, fwd_d;
    logic [MSG_LEN-1:0] resp_q, resp_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [7:0]         exch_q, exch_d;
    logic               detach_evt;

    cc_attach_debounce u_debounce (
        .clk        (clk),
        .reset      (reset),
        .cc1        (cc1),
        .cc2        (cc2),
        .attached   (attached),
        .orient     (orient),
        .detach_evt (detach_evt)
    );

    always_comb begin
        state_d = state_q;
        fwd_d   = fwd_q;
        resp_d  = resp_q;
        tmo_d   = tmo_q;
        exch_d  = exch_q;
        unique case (state_q)
            S_DETACHED: begin
                if (attached) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (req_valid) begin
                    if (ver_ok(req_msg)) begin
                        fwd_d   = req_msg;
                        tmo_d   = '0;
                        state_d = S_FWD_WAIT;
                    end else begin
                        resp_d  = error_msg(ERR_INVALID);
                        state_d = S_SEND;
                    end
                end
            end
            S_FWD_WAIT: begin
                // a reply landing on the expiry cycle beats the timeout
                if (rsp_valid) begin
                    resp_d  = ver_ok(rsp_msg) ? rsp_msg : error_msg(ERR_UNSPEC);
                    state_d = S_SEND;
                end else if (tmo_q == TMO_LAST) begin
                    resp_d  = error_msg(ERR_BUSY);
                    state_d = S_SEND;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_SEND: begin
                if (resp_ack) begin
                    exch_d  = exch_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_DETACHED;
        endcase
        if (detach_evt) begin
            state_d = S_DETACHED;
            fwd_d   = fwd_q;
            resp_d  = resp_q;
            tmo_d   = tmo_q;
            exch_d  = exch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_DETACHED;
            fwd_q   <= '0;
            resp_q  <= '0;
            tmo_q   <= '0;
            exch_q  <= '0;
        end else begin
            state_q <= state_d;
            fwd_q   <= fwd_d;
            resp_q  <= resp_d;
            tmo_q   <= tmo_d;
            exch_q  <= exch_d;
        end
    end

    assign req_ready  = state_q == S_IDLE;
    assign fwd_valid  = state_q == S_FWD_WAIT;
    assign resp_valid = state_q == S_SEND;
    assign fwd_msg    = fwd_q;
    assign resp_msg   = resp_q;
    assign exch_cnt   = exch_q;

endmodule
